// File: rtl/fp_mul_iter.sv
// fp_mul_iter: IEEE-754 single-precision multiplier built on an iterative shift-add
// mantissa datapath (one multiplier bit per cycle). The result is normalised,
// rounded to nearest-even and packed. Latency is the same for every operand pair.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset; also aborts an operation in flight
//   start      one-cycle pulse: latch op_a/op_b and begin (restarts if busy)
//   done       1 = idle with res/flags valid, 0 = busy
//   op_a/op_b  IEEE-754 single operands, sampled only on the start cycle
//   overflow   result saturated to infinity
//   underflow  nonzero product flushed to zero
//   exception  an input was Inf or NaN
//   res        packed product
module fp_mul_iter #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              done,
    output logic              overflow,
    output logic              underflow,
    output logic              exception,
    output logic [DATA_W-1:0] res
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_PACK} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [4:0]                r_cnt;
    logic [DATA_W-1:0]         r_a;
    logic [DATA_W-1:0]         r_b;
    logic [2*MAN_W-1:0]        r_acc;
    logic signed [9:0]         r_exp;
    logic [MAN_W-1:0]          r_m;
    logic                      r_g;
    logic                      r_s;
    logic                      r_done;
    logic                      r_ovf;
    logic                      r_unf;
    logic                      r_exc;
    logic [DATA_W-1:0]         r_res;

    // Nearest-even rounding; bit MAN_W of the result is the carry out of the mantissa.
    function automatic logic [MAN_W:0] f_round(input logic [MAN_W-1:0] m,
                                                input logic g, input logic s);
        logic up;
        up = g & (s | m[0]);
        return {1'b0, m} + {{MAN_W{1'b0}}, up};
    endfunction

    // Exponent saturation; returns {overflow, underflow, packed result}.
    function automatic logic [DATA_W+1:0] f_sat(input logic sign,
                                                 input logic signed [9:0] e,
                                                 input logic [MAN_W-2:0] frac);
        if (e >= 10'sd255)
            return {2'b10, sign, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
        else if (e <= 10'sd0)
            return {2'b01, sign, {(DATA_W-1){1'b0}}};
        else
            return {2'b00, sign, e[EXP_W-1:0], frac};
    endfunction

    logic [MAN_W-1:0]  w_ma;
    logic [MAN_W-1:0]  w_mb;
    logic [EXP_W-1:0]  w_ea;
    logic [EXP_W-1:0]  w_eb;
    logic              w_sign;
    logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [MAN_W:0]    w_rnd;
    logic [MAN_W-1:0]  w_m_rnd;
    logic signed [9:0] w_exp_rnd;
    logic [DATA_W+1:0] w_sat;
    logic [DATA_W-1:0] w_res;
    logic [2:0]        w_flags;

    assign w_ma     = {1'b1, r_a[MAN_W-2:0]};
    assign w_mb     = {1'b1, r_b[MAN_W-2:0]};
    assign w_ea     = r_a[DATA_W-2 -: EXP_W];
    assign w_eb     = r_b[DATA_W-2 -: EXP_W];
    assign w_sign   = r_a[DATA_W-1] ^ r_b[DATA_W-1];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == '1) && (r_a[MAN_W-2:0] == '0);
    assign w_b_inf  = (w_eb == '1) && (r_b[MAN_W-2:0] == '0);
    assign w_a_nan  = (w_ea == '1) && (r_a[MAN_W-2:0] != '0);
    assign w_b_nan  = (w_eb == '1) && (r_b[MAN_W-2:0] != '0);

    assign w_rnd     = f_round(r_m, r_g, r_s);
    // A carry out means the mantissa wrapped from all-ones: renormalise to 1.0.
    assign w_m_rnd   = w_rnd[MAN_W] ? {1'b1, {(MAN_W-1){1'b0}}} : w_rnd[MAN_W-1:0];
    assign w_exp_rnd = r_exp + (w_rnd[MAN_W] ? 10'sd1 : 10'sd0);
    assign w_sat     = f_sat(w_sign, w_exp_rnd, w_m_rnd[MAN_W-2:0]);

    // Special operands override the arithmetic result; flags are {ovf, unf, exc}.
    always_comb begin
        w_res   = w_sat[DATA_W-1:0];
        w_flags = {w_sat[DATA_W+1], w_sat[DATA_W], 1'b0};
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_res   = 32'h7FC0_0000;
            w_flags = 3'b001;
        end else if (w_a_inf || w_b_inf) begin
            w_res   = {w_sign, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
            w_flags = 3'b001;
        end else if (w_a_zero || w_b_zero) begin
            w_res   = {w_sign, {(DATA_W-1){1'b0}}};
            w_flags = 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = S_MUL;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_IDLE;
                S_MUL:  if (r_cnt == 5'd23) w_next = S_NORM;
                S_NORM: w_next = S_PACK;
                S_PACK: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_done <= 1'b1;
            r_res  <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_exc  <= 1'b0;
        end else if (start) begin
            // Latch operands and biased exponent sum; any operation in flight is dropped.
            r_a    <= op_a;
            r_b    <= op_b;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_exp  <= $signed({2'b00, op_a[DATA_W-2 -: EXP_W]})
                    + $signed({2'b00, op_b[DATA_W-2 -: EXP_W]}) - 10'sd127;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_exc  <= 1'b0;
        end else begin
            case (r_state)
                // Shift-add: one multiplier bit per cycle.
                S_MUL: begin
                    if (w_mb[r_cnt])
                        r_acc <= r_acc + ({{MAN_W{1'b0}}, w_ma} << r_cnt);
                    r_cnt <= (r_cnt == 5'd23) ? 5'd0 : r_cnt + 5'd1;
                end
                // Normalise: product of two [1,2) values lies in [1,4).
                S_NORM: begin
                    if (r_acc[2*MAN_W-1]) begin
                        r_m   <= r_acc[47:24];
                        r_g   <= r_acc[23];
                        r_s   <= |r_acc[22:0];
                        r_exp <= r_exp + 10'sd1;
                    end else begin
                        r_m   <= r_acc[46:23];
                        r_g   <= r_acc[22];
                        r_s   <= |r_acc[21:0];
                    end
                end
                // Round, saturate and pack.
                S_PACK: begin
                    r_res  <= w_res;
                    r_ovf  <= w_flags[2];
                    r_unf  <= w_flags[1];
                    r_exc  <= w_flags[0];
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done      = r_done;
    assign res       = r_res;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign exception = r_exc;

endmodule

// File: tb/tb_fp_mul_iter.sv
// tb_fp_mul_iter: directed bench for fp_mul_iter. Each task drives one scenario and
// compares result, flags and latency against hand-computed values.
module tb_fp_mul_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        done;
    logic        overflow;
    logic        underflow;
    logic        exception;
    logic [31:0] res;

    int checks = 0;
    int failures = 0;

    fp_mul_iter #(.DATA_W(32), .EXP_W(8), .MAN_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .done(done), .overflow(overflow), .underflow(underflow),
        .exception(exception), .res(res)
    );

    always #5 clk = ~clk;

    // Pulse start for one edge; returns after that edge (at the following negedge).
    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a  = 32'hDEAD_BEEF;
        op_b  = 32'hDEAD_BEEF;
    endtask

    // Cycles from the start edge until done is seen high; -1 if the bound expires.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL reset_done got=%b exp=1", done); end
        checks++; if (res !== 32'h0) begin failures++; $display("FAIL reset_res got=%h exp=00000000", res); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_unf got=%b exp=0", underflow); end
        checks++; if (exception !== 1'b0) begin failures++; $display("FAIL reset_exc got=%b exp=0", exception); end
    endtask

    task automatic test_normal;
        logic [31:0] va [4] = '{32'h4000_0000, 32'h3FC0_0000, 32'h3F80_0001, 32'h3F80_0800};
        logic [31:0] vb [4] = '{32'h4040_0000, 32'hBFC0_0000, 32'h3F80_0001, 32'h3F80_0800};
        logic [31:0] vr [4] = '{32'h40C0_0000, 32'hC010_0000, 32'h3F80_0002, 32'h3F80_1000};
        int lat;
        for (int i = 0; i < 4; i++) begin
            pulse_start(va[i], vb[i]);
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL normal%0d_busy got=%b exp=0", i, done); end
            wait_done(lat);
            checks++; if (lat !== 26) begin failures++; $display("FAIL normal%0d_latency got=%0d exp=26", i, lat); end
            checks++; if (res !== vr[i]) begin failures++; $display("FAIL normal%0d_res got=%h exp=%h", i, res, vr[i]); end
            checks++; if ({overflow, underflow, exception} !== 3'b000) begin
                failures++; $display("FAIL normal%0d_flags got=%b exp=000", i, {overflow, underflow, exception});
            end
        end
    endtask

    task automatic test_range;
        logic [31:0] va [2] = '{32'h7F00_0000, 32'h0080_0000};
        logic [31:0] vr [2] = '{32'h7F80_0000, 32'h0000_0000};
        logic [2:0]  vf [2] = '{3'b100, 3'b010};
        int lat;
        for (int i = 0; i < 2; i++) begin
            pulse_start(va[i], va[i]);
            wait_done(lat);
            checks++; if (lat !== 26) begin failures++; $display("FAIL range%0d_latency got=%0d exp=26", i, lat); end
            checks++; if (res !== vr[i]) begin failures++; $display("FAIL range%0d_res got=%h exp=%h", i, res, vr[i]); end
            checks++; if ({overflow, underflow, exception} !== vf[i]) begin
                failures++; $display("FAIL range%0d_flags got=%b exp=%b", i, {overflow, underflow, exception}, vf[i]);
            end
        end
        // The underflow flag from above must clear on the next start edge.
        pulse_start(32'h4000_0000, 32'h4000_0000);
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL flag_clear_on_start got=%b exp=0", underflow); end
        wait_done(lat);
        checks++; if (res !== 32'h4080_0000) begin failures++; $display("FAIL range_2x2_res got=%h exp=40800000", res); end
    endtask

    task automatic test_special;
        logic [31:0] va [5] = '{32'h7F80_0000, 32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'h0000_1234};
        logic [31:0] vb [5] = '{32'h0000_0000, 32'hC000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000};
        logic [31:0] vr [5] = '{32'h7FC0_0000, 32'h8000_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h0000_0000};
        logic [2:0]  vf [5] = '{3'b001, 3'b000, 3'b001, 3'b001, 3'b000};
        int lat;
        for (int i = 0; i < 5; i++) begin
            pulse_start(va[i], vb[i]);
            wait_done(lat);
            checks++; if (lat !== 26) begin failures++; $display("FAIL special%0d_latency got=%0d exp=26", i, lat); end
            checks++; if (res !== vr[i]) begin failures++; $display("FAIL special%0d_res got=%h exp=%h", i, res, vr[i]); end
            checks++; if ({overflow, underflow, exception} !== vf[i]) begin
                failures++; $display("FAIL special%0d_flags got=%b exp=%b", i, {overflow, underflow, exception}, vf[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        int early = 0;
        pulse_start(32'h4000_0000, 32'h4040_0000);
        // Second start lands on the 10th edge after the first.
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done) early++;
        end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_busy_before_restart got=%b exp=0", done); end
        pulse_start(32'h4080_0000, 32'h4080_0000);
        wait_done(lat);
        checks++; if (early !== 0) begin failures++; $display("FAIL b2b_early_done got=%0d exp=0", early); end
        checks++; if (lat !== 26) begin failures++; $display("FAIL b2b_latency got=%0d exp=26", lat); end
        checks++; if (res !== 32'h4180_0000) begin failures++; $display("FAIL b2b_res got=%h exp=41800000", res); end
    endtask

    task automatic test_rst_abort;
        pulse_start(32'h4000_0000, 32'h4040_0000);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL abort_done got=%b exp=1", done); end
        checks++; if (res !== 32'h0) begin failures++; $display("FAIL abort_res got=%h exp=00000000", res); end
        repeat (30) @(negedge clk);
        checks++; if (res !== 32'h0) begin failures++; $display("FAIL abort_stays_idle got=%h exp=00000000", res); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_range();
        test_special();
        test_back_to_back();
        test_rst_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
